toggle_pulse_decoder: RTL

- Receive end of the toggle-signalling scheme built on our T flip-flop. The sender flips a level once per event; this block recovers one event per flip.
- Synchronises the asynchronous toggle line and detects each level change.
- Emits a one-cycle pulse per change and queues pending events behind a valid/ready handshake for a downstream consumer.
- Also keeps a wrapping total-event count and a sticky overflow flag.

---
 rtl/toggle_pulse_decoder.sv | 85 ++++++++
 1 files changed

// File: rtl/toggle_pulse_decoder.sv
// Recovers one event per level flip on an asynchronous toggle line and queues events behind valid/ready.
// Pulse, pending and total_cnt update SYNC_STAGES edges after capture; saturated events set ovf.
module toggle_pulse_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int TOT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tog_in,
    input  logic              clr,
    input  logic              evt_ready,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pending,
    output logic [TOT_W-1:0]  total_cnt,
    output logic              ovf,
    output logic              level
);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = 1;
    localparam logic [TOT_W-1:0]  TOT_ONE  = 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pulse;
    logic                   r_ovf;
    logic [PEND_W-1:0]      r_pending;
    logic [TOT_W-1:0]       r_total;

    logic w_level;
    logic w_change;
    logic w_valid;
    logic w_accept;

    assign w_level  = r_sync[SYNC_STAGES-1];
    assign w_change = w_level ^ r_prev;
    assign w_valid  = (r_pending != '0);
    assign w_accept = w_valid & evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], tog_in};
            r_prev  <= w_level;
            r_pulse <= w_change;
        end
    end

    // clr wins over everything; a change that coincides with an accept nets to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_total   <= '0;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_pending <= '0;
            r_total   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_change) begin
                r_total <= r_total + TOT_ONE;
            end
            if (w_change && !w_accept) begin
                if (r_pending == PEND_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pending <= r_pending + PEND_ONE;
                end
            end else if (w_accept && !w_change) begin
                r_pending <= r_pending - PEND_ONE;
            end
        end
    end

    assign evt_pulse = r_pulse;
    assign evt_valid = w_valid;
    assign pending   = r_pending;
    assign total_cnt = r_total;
    assign ovf       = r_ovf;
    assign level     = w_level;
endmodule
